// File: rtl/shared_mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Covers FSM state encodings, port-select codes and a saturating counter helper.
package shared_mem_arbiter_pkg;

    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 32;
    localparam int STARVE_LIM = 4;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        DBG  = 2'd2,
        LOCK = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CPU  = 2'd1,
        SEL_DBG  = 2'd2
    } port_sel_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/shared_mem_arbiter_if.sv
// Bundle of CPU port, debug port and memory-side signals around the arbiter.
// The slave modport is the arbiter view; master is the requester/memory view.
interface shared_mem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_lock;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [15:0]       dbg_grants;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output dbg_grants
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  dbg_grants
    );

endinterface

// File: rtl/shared_mem_arbiter_arb_port_mux.sv
// Combinational 2:1 selector of the winning port's access onto the memory bus.
// With no winner the bus is parked at all-zero so the memory sees no activity.
module arb_port_mux
    import shared_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  port_sel_e         sel,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              en,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata
);

    always_comb begin
        en    = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        unique case (sel)
            SEL_CPU: begin
                en    = 1'b1;
                we    = cpu_we;
                addr  = cpu_addr;
                wdata = cpu_wdata;
            end
            SEL_DBG: begin
                en    = 1'b1;
                we    = dbg_we;
                addr  = dbg_addr;
                wdata = dbg_wdata;
            end
            default: begin
                en    = 1'b0;
                we    = 1'b0;
                addr  = '0;
                wdata = '0;
            end
        endcase
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// CPU-priority arbiter for the shared single-port memory with debug lock
// bursts, an anti-starvation limit for debug and a routed read-valid pipeline.
module shared_mem_arbiter
    import shared_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = shared_mem_arbiter_pkg::ADDR_W,
    parameter int DATA_W     = shared_mem_arbiter_pkg::DATA_W,
    parameter int STARVE_LIM = shared_mem_arbiter_pkg::STARVE_LIM
) (
    input logic                 clk,
    input logic                 rst,
    shared_mem_arbiter_if.slave bus
);

    localparam int SC_W = $clog2(STARVE_LIM + 1);
    localparam logic [SC_W-1:0] LIM = SC_W'(STARVE_LIM);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [SC_W-1:0]   starve_cnt;
    logic [CNT_W-1:0]  grant_cnt;
    logic              cpu_rvalid;
    logic              dbg_rvalid;

    logic              in_lock;
    logic              cpu_win;
    logic              dbg_win;
    port_sel_e         sel;

    // Reset gates both grants so nothing reaches the memory while rst is high.
    always_comb begin
        in_lock = (state == LOCK);
        dbg_win = !rst && bus.dbg_req &&
                  (in_lock || !bus.cpu_req || starve_cnt == LIM);
        cpu_win = !rst && !in_lock && bus.cpu_req && !dbg_win;
        sel     = SEL_NONE;
        if (dbg_win) begin
            sel = SEL_DBG;
        end else if (cpu_win) begin
            sel = SEL_CPU;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (cpu_win) begin
            state_nxt = CPU;
        end else if (dbg_win) begin
            state_nxt = bus.dbg_lock ? LOCK : DBG;
        end else if (in_lock && bus.dbg_lock) begin
            state_nxt = LOCK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            grant_cnt  <= '0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            cpu_rvalid <= cpu_win && !bus.cpu_we;
            dbg_rvalid <= dbg_win && !bus.dbg_we;
            if (dbg_win) begin
                starve_cnt <= '0;
                grant_cnt  <= sat_inc(grant_cnt);
            end else if (bus.dbg_req && starve_cnt != LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    arb_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .sel       (sel),
        .cpu_we    (bus.cpu_we),
        .cpu_addr  (bus.cpu_addr),
        .cpu_wdata (bus.cpu_wdata),
        .dbg_we    (bus.dbg_we),
        .dbg_addr  (bus.dbg_addr),
        .dbg_wdata (bus.dbg_wdata),
        .en        (bus.mem_en),
        .we        (bus.mem_we),
        .addr      (bus.mem_addr),
        .wdata     (bus.mem_wdata)
    );

    assign bus.cpu_gnt    = cpu_win;
    assign bus.dbg_gnt    = dbg_win;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.dbg_rvalid = dbg_rvalid;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dbg_rdata  = bus.mem_rdata;
    assign bus.dbg_grants = grant_cnt;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with a behavioural one-cycle memory.
// Memory word i is preloaded with 32'hA000_0000 | i.
module tb_shared_mem_arbiter;

    logic clk;
    logic rst;
    int   passed;
    int   failed;
    int   total;

    shared_mem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) ifc ();

    shared_mem_arbiter #(
        .ADDR_W     (9),
        .DATA_W     (32),
        .STARVE_LIM (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    logic [31:0] mem [0:511];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifc.mem_en) begin
            if (ifc.mem_we) begin
                mem[ifc.mem_addr] <= ifc.mem_wdata;
            end else begin
                ifc.mem_rdata <= mem[ifc.mem_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [5:0] cpu_exp;
        logic [5:0] dbg_exp;
        passed = 0;
        failed = 0;
        total  = 0;
        for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 | i;
        ifc.mem_rdata = '0;
        ifc.cpu_req   = 1'b1;
        ifc.cpu_we    = 1'b0;
        ifc.cpu_addr  = 9'h004;
        ifc.cpu_wdata = '0;
        ifc.dbg_req   = 1'b0;
        ifc.dbg_we    = 1'b0;
        ifc.dbg_addr  = '0;
        ifc.dbg_wdata = '0;
        ifc.dbg_lock  = 1'b0;
        rst = 1'b1;
        #3;
        chk("rst_cpu_gnt", {31'b0, ifc.cpu_gnt}, 32'd0);
        chk("rst_mem_en", {31'b0, ifc.mem_en}, 32'd0);
        chk("rst_mem_addr", {23'b0, ifc.mem_addr}, 32'd0);
        chk("rst_cpu_rvalid", {31'b0, ifc.cpu_rvalid}, 32'd0);
        chk("rst_grants", {16'b0, ifc.dbg_grants}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Test 1: first CPU read after reset
        #3;
        chk("t1_cpu_gnt", {31'b0, ifc.cpu_gnt}, 32'd1);
        chk("t1_mem_addr", {23'b0, ifc.mem_addr}, 32'h004);
        chk("t1_mem_en", {31'b0, ifc.mem_en}, 32'd1);
        tick();
        ifc.cpu_req = 1'b0;
        #3;
        chk("t1_cpu_rvalid", {31'b0, ifc.cpu_rvalid}, 32'd1);
        chk("t1_cpu_rdata", ifc.cpu_rdata, 32'hA000_0004);
        chk("t1_dbg_rvalid", {31'b0, ifc.dbg_rvalid}, 32'd0);
        tick();
        #3;
        chk("t1_rvalid_drop", {31'b0, ifc.cpu_rvalid}, 32'd0);
        chk("t1_idle_mem_en", {31'b0, ifc.mem_en}, 32'd0);

        // Test 2: starvation forces dbg through at cycle 4
        ifc.cpu_req  = 1'b1;
        ifc.cpu_addr = 9'h001;
        ifc.dbg_req  = 1'b1;
        ifc.dbg_addr = 9'h002;
        cpu_exp = 6'b101111;
        dbg_exp = 6'b010000;
        for (int k = 0; k < 6; k++) begin
            #3;
            chk($sformatf("t2_cpu_gnt_c%0d", k),
                {31'b0, ifc.cpu_gnt}, {31'b0, cpu_exp[k]});
            chk($sformatf("t2_dbg_gnt_c%0d", k),
                {31'b0, ifc.dbg_gnt}, {31'b0, dbg_exp[k]});
            if (k == 5) begin
                chk("t2_dbg_rvalid", {31'b0, ifc.dbg_rvalid}, 32'd1);
                chk("t2_dbg_rdata", ifc.dbg_rdata, 32'hA000_0002);
                chk("t2_cpu_rvalid", {31'b0, ifc.cpu_rvalid}, 32'd0);
            end
            tick();
        end
        ifc.cpu_req = 1'b0;
        ifc.dbg_req = 1'b0;
        tick();
        #3;
        chk("t2_grants", {16'b0, ifc.dbg_grants}, 32'd1);

        // Test 3: lock burst keeps the CPU out
        ifc.dbg_req   = 1'b1;
        ifc.dbg_lock  = 1'b1;
        ifc.dbg_we    = 1'b1;
        ifc.dbg_addr  = 9'h010;
        ifc.dbg_wdata = 32'h1111_0010;
        #1;
        chk("t3_c0_dbg_gnt", {31'b0, ifc.dbg_gnt}, 32'd1);
        chk("t3_c0_mem_we", {31'b0, ifc.mem_we}, 32'd1);
        chk("t3_c0_mem_addr", {23'b0, ifc.mem_addr}, 32'h010);
        chk("t3_c0_mem_wdata", ifc.mem_wdata, 32'h1111_0010);
        tick();
        ifc.cpu_req   = 1'b1;
        ifc.cpu_we    = 1'b0;
        ifc.cpu_addr  = 9'h003;
        ifc.dbg_addr  = 9'h011;
        ifc.dbg_wdata = 32'h1111_0011;
        #3;
        chk("t3_c1_dbg_gnt", {31'b0, ifc.dbg_gnt}, 32'd1);
        chk("t3_c1_cpu_gnt", {31'b0, ifc.cpu_gnt}, 32'd0);
        chk("t3_c1_no_wr_rvalid", {31'b0, ifc.dbg_rvalid}, 32'd0);
        tick();
        ifc.dbg_req = 1'b0;
        #3;
        chk("t3_c2_cpu_gnt", {31'b0, ifc.cpu_gnt}, 32'd0);
        chk("t3_c2_mem_en", {31'b0, ifc.mem_en}, 32'd0);
        tick();
        ifc.dbg_req   = 1'b1;
        ifc.dbg_addr  = 9'h012;
        ifc.dbg_wdata = 32'h1111_0012;
        #3;
        chk("t3_c3_dbg_gnt", {31'b0, ifc.dbg_gnt}, 32'd1);
        chk("t3_c3_cpu_gnt", {31'b0, ifc.cpu_gnt}, 32'd0);
        tick();
        ifc.dbg_req  = 1'b0;
        ifc.dbg_lock = 1'b0;
        ifc.dbg_we   = 1'b0;
        #3;
        chk("t3_c4_cpu_gnt", {31'b0, ifc.cpu_gnt}, 32'd0);
        tick();
        #3;
        chk("t3_c5_cpu_gnt", {31'b0, ifc.cpu_gnt}, 32'd1);
        chk("t3_c5_mem_addr", {23'b0, ifc.mem_addr}, 32'h003);
        tick();
        ifc.cpu_req = 1'b0;
        #3;
        chk("t3_c6_cpu_rvalid", {31'b0, ifc.cpu_rvalid}, 32'd1);
        chk("t3_c6_cpu_rdata", ifc.cpu_rdata, 32'hA000_0003);
        tick();

        // Test 4: alternating reads route to their own port
        ifc.cpu_req  = 1'b1;
        ifc.cpu_addr = 9'h001;
        #3;
        chk("t4_cpu_gnt", {31'b0, ifc.cpu_gnt}, 32'd1);
        tick();
        ifc.cpu_req  = 1'b0;
        ifc.dbg_req  = 1'b1;
        ifc.dbg_addr = 9'h002;
        #3;
        chk("t4_dbg_gnt", {31'b0, ifc.dbg_gnt}, 32'd1);
        chk("t4_cpu_rvalid", {31'b0, ifc.cpu_rvalid}, 32'd1);
        chk("t4_cpu_rdata", ifc.cpu_rdata, 32'hA000_0001);
        chk("t4_dbg_rvalid_lo", {31'b0, ifc.dbg_rvalid}, 32'd0);
        tick();
        ifc.dbg_addr = 9'h012;
        #3;
        chk("t4_dbg_rvalid", {31'b0, ifc.dbg_rvalid}, 32'd1);
        chk("t4_dbg_rdata", ifc.dbg_rdata, 32'hA000_0002);
        chk("t4_cpu_rvalid_lo", {31'b0, ifc.cpu_rvalid}, 32'd0);
        tick();
        ifc.dbg_req = 1'b0;
        #3;
        chk("t4_burst_readback", ifc.dbg_rdata, 32'h1111_0012);
        chk("t4_grants", {16'b0, ifc.dbg_grants}, 32'd6);
        tick();

        // Test 5: reset in the cycle after a read grant
        ifc.cpu_req  = 1'b1;
        ifc.cpu_addr = 9'h005;
        #3;
        chk("t5_cpu_gnt", {31'b0, ifc.cpu_gnt}, 32'd1);
        tick();
        rst = 1'b1;
        ifc.cpu_req = 1'b0;
        #1;
        chk("t5_rvalid_dropped", {31'b0, ifc.cpu_rvalid}, 32'd0);
        tick();
        rst = 1'b0;
        #3;
        chk("t5_state_idle", {30'b0, dut.state}, 32'd0);
        chk("t5_rvalid_after", {31'b0, ifc.cpu_rvalid}, 32'd0);
        chk("t5_grants_cleared", {16'b0, ifc.dbg_grants}, 32'd0);

        // Test 6: grant counter saturation
        ifc.dbg_req  = 1'b1;
        ifc.dbg_lock = 1'b1;
        ifc.dbg_we   = 1'b1;
        ifc.dbg_addr = 9'h100;
        for (int n = 0; n < 65534; n++) tick();
        #3;
        chk("t6_grants_fffe", {16'b0, ifc.dbg_grants}, 32'h0000_FFFE);
        for (int n = 0; n < 3; n++) tick();
        #3;
        chk("t6_grants_sat", {16'b0, ifc.dbg_grants}, 32'h0000_FFFF);
        ifc.dbg_req  = 1'b0;
        ifc.dbg_lock = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
